mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 select path between four requesters (a, b, c, d). It grants one requester at a time and drives the registered 2-bit select. It forwards the granted requester's data onto a single valid/ready output channel, with a bounded burst length per grant. It sits in front of the team's 4x1 mux and replaces free-running select stimulus with a real scheduler.

Parameters:
DATA_W, 1, width of each data input and of out_data
MAX_BURST, 4, maximum beats transferred per grant; legal range 1..256
BEAT_W, $clog2(MAX_BURST)+1, beat counter width (localparam, derived)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request vector; bit0=a, bit1=b, bit2=c, bit3=d
a  input  DATA_W  requester 0 data
b  input  DATA_W  requester 1 data
c  input  DATA_W  requester 2 data
d  input  DATA_W  requester 3 data
out_ready  input  1  downstream accepts a beat
gnt  output  4  one-hot grant, registered
sel  output  2  registered mux select (0=a, 1=b, 2=c, 3=d)
out_valid  output  1  beat present on out_data
out_data  output  DATA_W  selected data, a/b/c/d muxed by sel
busy  output  1  high while a grant is held
lock  input  1  only present when MUX_ARB_LOCK_EN is defined

Behaviour:
- Interface: one clock, clk; reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, out_valid=0, beat_cnt=0, last_sel=2'b11. Requester 0 therefore wins first.
- FSM has two states, IDLE and GRANT.
- IDLE, req==0: stay in IDLE, with gnt=0 and busy=0.
- IDLE, req!=0:
  - Pick the first set req bit, searching from last_sel+1 mod 4 upward with wrap.
  - Next edge: sel<=winner, gnt<=onehot(winner), last_sel<=winner, beat_cnt<=0, state<=GRANT.
  - Arbitration latency: 1 cycle from req to gnt.
- GRANT:
  - busy=1.
  - out_valid = req[sel] (combinational from registered sel).
  - out_data = mux(a,b,c,d; sel), valid whenever out_valid=1; don't-care otherwise.
- Transfer condition: out_valid && out_ready. On a transfer, beat_cnt increments.
- GRANT exits to IDLE on the next edge, clearing gnt, when either:
  - a transfer occurs with beat_cnt==MAX_BURST-1, or
  - req[sel]==0 (requester dropped; this beat is not transferred).
- One idle cycle is inserted between grants; minimum re-arbitration gap is 1 cycle.
- out_ready low: hold state, sel and beat_cnt; no timeout.
- Other requests changing during GRANT have no effect until the return to IDLE.
- Simultaneous final transfer plus new requests: go to IDLE first; the next winner is evaluated from the updated last_sel.
- MAX_BURST=1: exactly one beat per grant.
- Fairness: with all four req held high continuously, grant order is 0,1,2,3,0,...; no requester waits more than 3 grants.
- Reset mid-burst: all registers return to reset values immediately (asynchronous); out_valid drops without waiting for clk.
- sel never changes while out_valid=1 and out_ready=0.

Optional Feature:
MUX_ARB_LOCK_EN
- Defined:
  - Adds the lock input.
  - While in GRANT with lock=1, burst-length expiry is ignored and the grant is held until req[sel] drops or lock falls.
  - If lock falls with beat_cnt>=MAX_BURST-1, exit after the current transfer.
  - beat_cnt saturates at MAX_BURST-1.
- Not defined: no lock port; behaviour exactly as above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release with req=0 -> gnt=0000, sel=00, out_valid=0, busy=0 for 10 cycles.
- Single burst: req=0001, a=1, out_ready=1 -> gnt=0001 one cycle after req, 4 transfers with out_data=1, then gnt=0000 for 1 cycle, then re-grant to 0.
- Round robin: req=1111 held, out_ready=1, MAX_BURST=4 -> sel sequence 0,1,2,3,0; 4 beats each; 1 idle cycle between grants.
- Backpressure and drop:
  - req=0100, out_ready=0 for 5 cycles -> sel=10 stable, beat_cnt=0.
  - Then out_ready=1 for 2 beats, then req drops -> exit to IDLE with 2 beats counted.
- Reset mid-burst: assert rst_n=0 after beat 2 of a grant to requester 3 -> outputs reset asynchronously; after release with req=1000, requester 3 is granted (search starts at 0, no other req).
- Lock (MUX_ARB_LOCK_EN): req=0011, lock=1 on requester 0 -> 8 consecutive beats from a without switching; lock=0 -> exit after the current beat; next grant goes to 1.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// +------------------------------------------------------------------+
// | Module   : mux4_rr_arbiter_if                                     |
// | Brief    : Request/data/grant and output-channel bundle between   |
// |            four requesters and the round-robin 4:1 arbiter.       |
// |            MUX_ARB_LOCK_EN adds the lock signal.                   |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 1
);
  logic [3:0]        req;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic              out_ready;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;
`ifdef MUX_ARB_LOCK_EN
  logic              lock;

  // Requester/downstream side
  modport master (
    output req, a, b, c, d, out_ready, lock,
    input  gnt, sel, out_valid, out_data, busy
  );

  // Arbiter side
  modport slave (
    input  req, a, b, c, d, out_ready, lock,
    output gnt, sel, out_valid, out_data, busy
  );
`else
  // Requester/downstream side
  modport master (
    output req, a, b, c, d, out_ready,
    input  gnt, sel, out_valid, out_data, busy
  );

  // Arbiter side
  modport slave (
    input  req, a, b, c, d, out_ready,
    output gnt, sel, out_valid, out_data, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// +------------------------------------------------------------------+
// | Module   : mux4_rr_arbiter                                        |
// | Brief    : Round-robin scheduler for a shared 4:1 select path.    |
// |            Grants one requester at a time, drives the registered  |
// |            select and forwards the granted data on a valid/ready  |
// |            channel with at most MAX_BURST beats per grant.        |
// |            Optional feature macro: MUX_ARB_LOCK_EN (lock input    |
// |            holds the grant beyond the burst limit).               |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module mux4_rr_arbiter #(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0]        c_st_idle   = 1'b0;
  localparam logic [0:0]        c_st_grant  = 1'b1;
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(MAX_BURST - 1);

  logic [0:0]        r_state;
  logic [1:0]        r_sel;
  logic [3:0]        r_gnt;
  logic [1:0]        r_last_sel;
  logic [BEAT_W-1:0] r_beat_cnt;

  logic [0:0]        w_nxt_state;
  logic [1:0]        w_nxt_sel;
  logic [3:0]        w_nxt_gnt;
  logic [1:0]        w_nxt_last_sel;
  logic [BEAT_W-1:0] w_nxt_beat_cnt;

  logic              w_win_found;
  logic [1:0]        w_win;
  logic              w_busy;
  logic              w_req_sel;
  logic              w_out_valid;
  logic              w_xfer;
  logic              w_burst_done;
  logic              w_beat_sat;
  logic [DATA_W-1:0] w_out_data;

  // Round-robin search: lowest offset (1..4) from last_sel with req set wins.
  // Scanning offsets from high to low lets the nearest hit overwrite the rest.
  always_comb begin
    w_win_found = 1'b0;
    w_win       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[r_last_sel + 2'(i + 1)]) begin
        w_win_found = 1'b1;
        w_win       = r_last_sel + 2'(i + 1);
      end
    end
  end

  // Burst expiry; with lock enabled the counter saturates and expiry waits for lock to fall.
  always_comb begin
`ifdef MUX_ARB_LOCK_EN
    w_burst_done = !bus.lock && (r_beat_cnt >= c_last_beat);
    w_beat_sat   = (r_beat_cnt >= c_last_beat);
`else
    w_burst_done = (r_beat_cnt == c_last_beat);
    w_beat_sat   = 1'b0;
`endif
  end

  // State register: all arbiter state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_sel      <= 2'b00;
      r_gnt      <= 4'b0000;
      r_last_sel <= 2'b11;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_sel      <= w_nxt_sel;
      r_gnt      <= w_nxt_gnt;
      r_last_sel <= w_nxt_last_sel;
      r_beat_cnt <= w_nxt_beat_cnt;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and decide exit in GRANT.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_sel      = r_sel;
    w_nxt_gnt      = r_gnt;
    w_nxt_last_sel = r_last_sel;
    w_nxt_beat_cnt = r_beat_cnt;
    case (r_state)
      c_st_idle: begin
        w_nxt_gnt = 4'b0000;
        if (w_win_found) begin
          w_nxt_state    = c_st_grant;
          w_nxt_sel      = w_win;
          w_nxt_gnt      = 4'b0001 << w_win;
          w_nxt_last_sel = w_win;
          w_nxt_beat_cnt = '0;
        end
      end
      c_st_grant: begin
        if (!w_req_sel) begin
          // Requester withdrew: leave without transferring.
          w_nxt_state = c_st_idle;
          w_nxt_gnt   = 4'b0000;
        end else if (w_xfer) begin
          if (!w_beat_sat) begin
            w_nxt_beat_cnt = r_beat_cnt + 1'b1;
          end
          if (w_burst_done) begin
            w_nxt_state = c_st_idle;
            w_nxt_gnt   = 4'b0000;
          end
        end
      end
      default: begin
        w_nxt_state = c_st_idle;
        w_nxt_gnt   = 4'b0000;
      end
    endcase
  end

  // Output logic: valid follows the granted request, data muxed by registered sel.
  always_comb begin
    w_busy      = (r_state == c_st_grant);
    w_req_sel   = bus.req[r_sel];
    w_out_valid = w_busy && w_req_sel;
    w_xfer      = w_out_valid && bus.out_ready;
    case (r_sel)
      2'd0:    w_out_data = bus.a;
      2'd1:    w_out_data = bus.b;
      2'd2:    w_out_data = bus.c;
      default: w_out_data = bus.d;
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.busy      = w_busy;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// +------------------------------------------------------------------+
// | Module   : tb_mux4_rr_arbiter                                     |
// | Brief    : Directed vector bench for the round-robin arbiter.     |
// |            Lock rows are added when MUX_ARB_LOCK_EN is defined.   |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  localparam logic [7:0] c_da = 8'hA1;
  localparam logic [7:0] c_db = 8'hB2;
  localparam logic [7:0] c_dc = 8'hC3;
  localparam logic [7:0] c_dd = 8'hD4;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic       lock;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  vec_t vecs[$];

  mux4_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mux4_rr_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(input logic [1:0] s);
    case (s)
      2'd0:    return c_da;
      2'd1:    return c_db;
      2'd2:    return c_dc;
      default: return c_dd;
    endcase
  endfunction

  task automatic add(input logic rs, input logic [3:0] rq, input logic rdy, input logic lk,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic bz);
    vec_t t;
    t.rst_n = rs; t.req = rq; t.rdy = rdy; t.lock = lk;
    t.gnt = g; t.sel = s; t.valid = v; t.busy = bz;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic bz);
    n_vec++;
    chk({tag, ".gnt"},   8'(bus.gnt),       8'(g));
    chk({tag, ".sel"},   8'(bus.sel),       8'(s));
    chk({tag, ".valid"}, 8'(bus.out_valid), 8'(v));
    chk({tag, ".busy"},  8'(bus.busy),      8'(bz));
    if (v) chk({tag, ".data"}, 8'(bus.out_data), data_of(s));
  endtask

  // Drive one row just after the falling edge, check shortly after.
  task automatic run_row(input int idx, input vec_t v);
    @(negedge clk);
    rst_n         = v.rst_n;
    bus.req       = v.req;
    bus.out_ready = v.rdy;
`ifdef MUX_ARB_LOCK_EN
    bus.lock      = v.lock;
`endif
    #1;
    chk_all($sformatf("row%0d", idx), v.gnt, v.sel, v.valid, v.busy);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // ---------------- vector table ----------------
    // Single burst to requester 0 (last_sel starts at 3)
    add(1, 4'h1, 1, 0, 4'h0, 2'd0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 4'h1, 1, 0, 4'h1, 2'd0, 1, 1);
    add(1, 4'h1, 1, 0, 4'h0, 2'd0, 0, 0);   // idle gap
    add(1, 4'h1, 1, 0, 4'h1, 2'd0, 1, 1);   // re-grant to 0
    add(1, 4'h0, 1, 0, 4'h1, 2'd0, 0, 1);   // dropped: no valid
    add(1, 4'h0, 1, 0, 4'h0, 2'd0, 0, 0);
    // Round robin from reset, all requesting
    add(0, 4'h0, 1, 0, 4'h0, 2'd0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      add(1, 4'hF, 1, 0, 4'h0, 2'(g == 0 ? 0 : g - 1), 0, 0);
      for (int i = 0; i < 4; i++) add(1, 4'hF, 1, 0, 4'(1 << g), 2'(g), 1, 1);
    end
    add(1, 4'hF, 1, 0, 4'h0, 2'd3, 0, 0);
    add(1, 4'hF, 1, 0, 4'h1, 2'd0, 1, 1);   // wraps back to 0
    add(1, 4'h0, 1, 0, 4'h1, 2'd0, 0, 1);
    add(1, 4'h0, 1, 0, 4'h0, 2'd0, 0, 0);
    // Backpressure on requester 2, two beats, then drop
    add(1, 4'h4, 0, 0, 4'h0, 2'd0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 4'h4, 0, 0, 4'h4, 2'd2, 1, 1);
    add(1, 4'h4, 1, 0, 4'h4, 2'd2, 1, 1);
    add(1, 4'hF, 1, 0, 4'h4, 2'd2, 1, 1);   // other requests ignored mid-grant
    add(1, 4'h0, 1, 0, 4'h4, 2'd2, 0, 1);
    add(1, 4'h0, 1, 0, 4'h0, 2'd2, 0, 0);
    // Requester 3 burst, asynchronous reset after beat 2
    add(1, 4'h8, 1, 0, 4'h0, 2'd2, 0, 0);
    add(1, 4'h8, 1, 0, 4'h8, 2'd3, 1, 1);
    add(1, 4'h8, 1, 0, 4'h8, 2'd3, 1, 1);
    add(0, 4'h8, 1, 0, 4'h0, 2'd0, 0, 0);   // checked before any rising edge
    add(1, 4'h8, 1, 0, 4'h0, 2'd0, 0, 0);
    add(1, 4'h8, 1, 0, 4'h8, 2'd3, 1, 1);
    add(1, 4'h0, 1, 0, 4'h8, 2'd3, 0, 1);
    add(1, 4'h0, 1, 0, 4'h0, 2'd3, 0, 0);
`ifdef MUX_ARB_LOCK_EN
    // Lock holds requester 0 past the burst limit
    add(0, 4'h0, 1, 0, 4'h0, 2'd0, 0, 0);
    add(1, 4'h3, 1, 1, 4'h0, 2'd0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 4'h3, 1, 1, 4'h1, 2'd0, 1, 1);
    add(1, 4'h3, 1, 0, 4'h1, 2'd0, 1, 1);   // lock falls: last beat
    add(1, 4'h3, 1, 0, 4'h0, 2'd0, 0, 0);
    add(1, 4'h3, 1, 0, 4'h2, 2'd1, 1, 1);
    add(1, 4'h0, 1, 0, 4'h2, 2'd1, 0, 1);
    add(1, 4'h0, 1, 0, 4'h0, 2'd1, 0, 0);
`endif

    // ---------------- reset then idle ----------------
    rst_n         = 1'b0;
    bus.req       = 4'h0;
    bus.out_ready = 1'b1;
    bus.a         = c_da;
    bus.b         = c_db;
    bus.c         = c_dc;
    bus.d         = c_dd;
`ifdef MUX_ARB_LOCK_EN
    bus.lock      = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_all($sformatf("rst%0d", i), 4'h0, 2'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk_all($sformatf("idle%0d", i), 4'h0, 2'd0, 1'b0, 1'b0);
    end

    // ---------------- table ----------------
    foreach (vecs[i]) run_row(i, vecs[i]);

    // ---------------- asynchronous reset mid-cycle ----------------
    @(negedge clk);
    bus.req = 4'h2;
    @(negedge clk);
    #1;
    chk_all("async_pre", 4'h2, 2'd1, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_drop", 4'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'h0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
